// File: rtl/reg_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_hazard_scoreboard
//
// Tracks how many writes are in flight for each architectural register and
// tells decode when it must hold. An instruction stalls while any source it
// reads has a pending write (RAW), or while its destination counter is already
// saturated (WAW full). Writeback retirement and squash of killed writers
// decrement the counters; flush_all clears them all. Register 0 is never
// tracked.
//
// Optional feature: define HAZARD_STATS_EN to add the saturating
// stall_cycles / waw_stall_cycles performance counters.
//
// Ports
//   clk, rst             clock (rising edge), async active-low reset
//   dec_*                decode-stage instruction fields and valid
//   issue_ready          execute stage accepts the instruction
//   wb_valid, wb_rd      writeback retires one write to wb_rd
//   squash_valid/_rd     one killed in-flight writer to squash_rd is dropped
//   flush_all            clear every counter (error flag is kept)
//   stall                decode must hold (combinational)
//   issue_fire           instruction issues this cycle (combinational)
//   busy_mask            registered, bit r = register r has pending writes
//   underflow_err        sticky: a decrement hit a counter already at zero
//   stall_cycles         (HAZARD_STATS_EN) cycles with stall asserted
//   waw_stall_cycles     (HAZARD_STATS_EN) stall cycles caused only by WAW
// -----------------------------------------------------------------------------
module reg_hazard_scoreboard #(
  parameter  int REGISTER_DEPTH = 32,
  parameter  int CNT_WIDTH      = 2,
  localparam int AW             = $clog2(REGISTER_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [AW-1:0]             dec_rs1,
  input  logic                      dec_rs1_used,
  input  logic [AW-1:0]             dec_rs2,
  input  logic                      dec_rs2_used,
  input  logic [AW-1:0]             dec_rd,
  input  logic                      dec_rd_write,
  input  logic                      issue_ready,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_rd,
  input  logic                      squash_valid,
  input  logic [AW-1:0]             squash_rd,
  input  logic                      flush_all,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [REGISTER_DEPTH-1:0] busy_mask,
  output logic                      underflow_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               waw_stall_cycles
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]      r_count [REGISTER_DEPTH];
  logic [REGISTER_DEPTH-1:0] r_busy;
  logic                      r_underflow;

  logic [CNT_WIDTH-1:0]      w_next  [REGISTER_DEPTH];
  logic [CNT_WIDTH:0]        w_up    [REGISTER_DEPTH];
  logic [1:0]                w_down  [REGISTER_DEPTH];
  logic                      w_underflow;
  logic                      w_raw_hit;
  logic                      w_waw_full;

  // Hazard detection looks only at registered counters: a writeback in this
  // cycle releases a waiting reader no earlier than the next cycle.
  always_comb begin
    // NOTE: every comb output gets a value on every path, so no latch is inferred.
    w_raw_hit  = (dec_rs1_used && (dec_rs1 != '0) && (r_count[dec_rs1] != '0)) ||
                 (dec_rs2_used && (dec_rs2 != '0) && (r_count[dec_rs2] != '0));
    w_waw_full = dec_rd_write && (dec_rd != '0) && (r_count[dec_rd] == CNT_MAX);
    stall      = dec_valid && (w_raw_hit || w_waw_full);
    issue_fire = dec_valid && !stall && issue_ready;
  end

  // Per-register next count. The increment is computed one bit wider so that
  // "decrements exceed count + inc" is a plain compare; that case clamps to 0
  // and raises the error. flush_all overrides every event.
  always_comb begin
    w_underflow = 1'b0;
    for (int r = 0; r < REGISTER_DEPTH; r++) begin
      w_up[r]   = {1'b0, r_count[r]} +
                  (CNT_WIDTH+1)'(issue_fire && dec_rd_write && (dec_rd == AW'(r)));
      w_down[r] = 2'(wb_valid && (wb_rd == AW'(r))) +
                  2'(squash_valid && (squash_rd == AW'(r)));
      w_next[r] = '0;
      if ((r != 0) && !flush_all) begin
        if ((CNT_WIDTH+1)'(w_down[r]) > w_up[r]) begin
          w_underflow = 1'b1;
        end else begin
          w_next[r] = CNT_WIDTH'(w_up[r] - (CNT_WIDTH+1)'(w_down[r]));
        end
      end
    end
  end

  // NOTE: the counter array must clear on reset (hazard state), so it lives in
  // flops with an async clear rather than in an inferred RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REGISTER_DEPTH; r++) begin
        r_count[r] <= '0;
      end
      r_busy      <= '0;
      r_underflow <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample together.
      for (int r = 0; r < REGISTER_DEPTH; r++) begin
        r_count[r] <= w_next[r];
        r_busy[r]  <= (w_next[r] != '0);
      end
      r_underflow <= r_underflow || w_underflow;
    end
  end

  assign busy_mask     = r_busy;
  assign underflow_err = r_underflow;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_waw_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles     <= '0;
      r_waw_stall_cycles <= '0;
    end else begin
      if (stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (stall && !w_raw_hit && (r_waw_stall_cycles != '1)) begin
        r_waw_stall_cycles <= r_waw_stall_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles     = r_stall_cycles;
  assign waw_stall_cycles = r_waw_stall_cycles;
`endif

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_hazard_scoreboard
//
// Drives reg_hazard_scoreboard with directed scenarios followed by random
// traffic. A behavioural model (an integer count per register) predicts
// stall, issue_fire, busy_mask and underflow_err every cycle; a few literal
// expectations pin the model on hand-computed scenarios.
// -----------------------------------------------------------------------------
module tb_reg_hazard_scoreboard;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int MAXC  = 3;

  logic             clk;
  logic             rst;
  logic             dec_valid;
  logic [AW-1:0]    dec_rs1;
  logic             dec_rs1_used;
  logic [AW-1:0]    dec_rs2;
  logic             dec_rs2_used;
  logic [AW-1:0]    dec_rd;
  logic             dec_rd_write;
  logic             issue_ready;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic             squash_valid;
  logic [AW-1:0]    squash_rd;
  logic             flush_all;
  logic             stall;
  logic             issue_fire;
  logic [DEPTH-1:0] busy_mask;
  logic             underflow_err;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      waw_stall_cycles;
  longint           m_sc;
  longint           m_wc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_cnt [DEPTH];
  bit m_uf;
  bit m_raw;
  bit m_stall;
  bit m_fire;

  reg_hazard_scoreboard #(.REGISTER_DEPTH(DEPTH), .CNT_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs1_used  (dec_rs1_used),
    .dec_rs2       (dec_rs2),
    .dec_rs2_used  (dec_rs2_used),
    .dec_rd        (dec_rd),
    .dec_rd_write  (dec_rd_write),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .squash_valid  (squash_valid),
    .squash_rd     (squash_rd),
    .flush_all     (flush_all),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .busy_mask     (busy_mask),
    .underflow_err (underflow_err)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .waw_stall_cycles (waw_stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    dec_valid    = 1'b0;
    dec_rs1      = '0;
    dec_rs1_used = 1'b0;
    dec_rs2      = '0;
    dec_rs2_used = 1'b0;
    dec_rd       = '0;
    dec_rd_write = 1'b0;
    issue_ready  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    squash_valid = 1'b0;
    squash_rd    = '0;
    flush_all    = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_cnt[r] = 0;
    m_uf = 1'b0;
`ifdef HAZARD_STATS_EN
    m_sc = 0;
    m_wc = 0;
`endif
  endtask

  // Set up a write-only instruction to rd with execute ready.
  task automatic issue_w(input int rd);
    idle();
    dec_valid    = 1'b1;
    dec_rd       = AW'(rd);
    dec_rd_write = 1'b1;
    issue_ready  = 1'b1;
  endtask

  // Called with inputs applied just after a falling edge: predict the outputs
  // from the model and compare, away from the rising edge.
  task automatic eval();
    logic [DEPTH-1:0] exp_busy;
    bit               waw;
    #1;
    m_raw   = (dec_rs1_used && dec_rs1 != 0 && m_cnt[dec_rs1] > 0) ||
              (dec_rs2_used && dec_rs2 != 0 && m_cnt[dec_rs2] > 0);
    waw     = dec_rd_write && dec_rd != 0 && m_cnt[dec_rd] == MAXC;
    m_stall = dec_valid && (m_raw || waw);
    m_fire  = dec_valid && !m_stall && issue_ready;
    exp_busy = '0;
    for (int r = 1; r < DEPTH; r++) exp_busy[r] = (m_cnt[r] != 0);
    check("stall", 64'(stall), 64'(m_stall));
    check("issue_fire", 64'(issue_fire), 64'(m_fire));
    check("busy_mask", 64'(busy_mask), 64'(exp_busy));
    check("underflow_err", 64'(underflow_err), 64'(m_uf));
`ifdef HAZARD_STATS_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_sc));
    check("waw_stall_cycles", 64'(waw_stall_cycles), 64'(m_wc));
`endif
  endtask

  // Apply the rising edge to the model, then move to the next falling edge.
  task automatic adv();
    int n;
`ifdef HAZARD_STATS_EN
    if (m_stall && m_sc < 64'hFFFF_FFFF) m_sc++;
    if (m_stall && !m_raw && m_wc < 64'hFFFF_FFFF) m_wc++;
`endif
    if (flush_all) begin
      for (int r = 0; r < DEPTH; r++) m_cnt[r] = 0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        n = m_cnt[r];
        if (m_fire && dec_rd_write && dec_rd == r) n++;
        if (wb_valid && wb_rd == r) n--;
        if (squash_valid && squash_rd == r) n--;
        if (n < 0) begin
          n    = 0;
          m_uf = 1'b1;
        end
        m_cnt[r] = n;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    #3;
    check("reset busy_mask", 64'(busy_mask), 64'h0);
    check("reset underflow_err", 64'(underflow_err), 64'h0);
    check("reset stall", 64'(stall), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // RAW on r5, released only the cycle after its writeback.
    issue_w(5); eval();
    check("issue r5 fire", 64'(issue_fire), 64'h1);
    adv();
    idle(); dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs1_used = 1'b1; issue_ready = 1'b1;
    eval();
    check("busy after r5", 64'(busy_mask), 64'h20);
    check("raw r5 stall", 64'(stall), 64'h1);
    adv();
    wb_valid = 1'b1; wb_rd = 5'd5;
    eval();
    check("raw r5 no bypass", 64'(stall), 64'h1);
    adv();
    wb_valid = 1'b0;
    eval();
    check("raw r5 released", 64'(issue_fire), 64'h1);
    adv();

    // Register 0 is never tracked.
    issue_w(0); eval(); adv();
    idle(); dec_valid = 1'b1; dec_rs1_used = 1'b1; issue_ready = 1'b1;
    eval();
    check("r0 no stall", 64'(stall), 64'h0);
    check("r0 busy", 64'(busy_mask), 64'h0);
    adv();

    // Saturate r7, fourth write blocks until one retires.
    for (int i = 0; i < 3; i++) begin
      issue_w(7); eval(); adv();
    end
    issue_w(7); eval();
    check("model cnt7", 64'(m_cnt[7]), 64'd3);
    check("waw full stall", 64'(stall), 64'h1);
    adv();
    wb_valid = 1'b1; wb_rd = 5'd7;
    eval();
    check("waw stall during wb", 64'(stall), 64'h1);
    adv();
    wb_valid = 1'b0;
    eval();
    check("waw fourth issues", 64'(issue_fire), 64'h1);
    adv();

    // Inc and wb on the same register cancel.
    issue_w(9); eval(); adv();
    issue_w(9); wb_valid = 1'b1; wb_rd = 5'd9; eval(); adv();
    idle(); eval();
    check("model cnt9", 64'(m_cnt[9]), 64'd1);
    check("busy bit9", 64'(busy_mask[9]), 64'h1);
    adv();

    // wb + squash on r3 decrement by two; one more wb underflows.
    issue_w(3); eval(); adv();
    issue_w(3); eval(); adv();
    idle(); wb_valid = 1'b1; wb_rd = 5'd3; squash_valid = 1'b1; squash_rd = 5'd3;
    eval(); adv();
    idle(); eval();
    check("busy bit3 clear", 64'(busy_mask[3]), 64'h0);
    check("no underflow yet", 64'(underflow_err), 64'h0);
    adv();
    wb_valid = 1'b1; wb_rd = 5'd3; eval(); adv();
    idle(); eval();
    check("underflow set", 64'(underflow_err), 64'h1);
    adv();
    flush_all = 1'b1; eval(); adv();
    idle(); eval();
    check("underflow after flush", 64'(underflow_err), 64'h1);
    check("busy after flush", 64'(busy_mask), 64'h0);
    adv();

    // flush_all beats a same-cycle issue.
    issue_w(4); eval(); adv();
    issue_w(4); flush_all = 1'b1; eval(); adv();
    idle(); eval();
    check("flush beats issue", 64'(busy_mask), 64'h0);
    adv();

    // Async reset in the middle of a cycle.
    issue_w(6); eval(); adv();
    idle();
    #2 rst = 1'b0;
    #1;
    check("async rst busy", 64'(busy_mask), 64'h0);
    check("async rst underflow", 64'(underflow_err), 64'h0);
    check("async rst stall", 64'(stall), 64'h0);
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);

    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      idle();
      dec_valid    = ($urandom_range(3) != 0);
      dec_rs1      = AW'($urandom_range(7));
      dec_rs1_used = $urandom_range(1) == 1;
      dec_rs2      = AW'($urandom_range(7));
      dec_rs2_used = $urandom_range(1) == 1;
      dec_rd       = AW'($urandom_range(7));
      dec_rd_write = ($urandom_range(3) != 0);
      issue_ready  = ($urandom_range(3) != 0);
      wb_valid     = ($urandom_range(2) == 0);
      wb_rd        = AW'($urandom_range(7));
      squash_valid = ($urandom_range(7) == 0);
      squash_rd    = AW'($urandom_range(7));
      flush_all    = ($urandom_range(63) == 0);
      if (flush_all) begin
        wb_valid     = 1'b0;
        squash_valid = 1'b0;
      end
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Per-register RAW/WAW hazard scoreboard that sequences the decode stage's use of the register-file read ports.
- Counts in-flight writes per architectural register and stalls decode while a source operand, or a saturated destination, is pending.
- Counters are decremented by writeback retirement and by squash of killed instructions.
- Sits beside decode: its stall output gates the decode-to-execute handshake and its drop input.

Parameters:
- REGISTER_DEPTH, 32, number of architectural registers; register 0 is never tracked.
- CNT_WIDTH, 2, width of each pending-write counter; at most 2^CNT_WIDTH-1 in-flight writes per register.
- AW, $clog2(REGISTER_DEPTH), register address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert assumed from upstream synchronizer.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  AW  source register 1.
- dec_rs1_used  in  1  rs1 is read.
- dec_rs2  in  AW  source register 2.
- dec_rs2_used  in  1  rs2 is read.
- dec_rd  in  AW  destination register.
- dec_rd_write  in  1  instruction writes rd.
- issue_ready  in  1  execute accepts (downstream tready).
- wb_valid  in  1  writeback retires a write.
- wb_rd  in  AW  writeback destination.
- squash_valid  in  1  a killed in-flight writer is dropped.
- squash_rd  in  AW  destination of the squashed writer.
- flush_all  in  1  clear every counter.
- stall  out  1  decode must hold (combinational).
- issue_fire  out  1  instruction issues this cycle (combinational).
- busy_mask  out  REGISTER_DEPTH  registered; bit r = (count[r] != 0).
- underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async): all counters 0, busy_mask 0, underflow_err 0; stall/issue_fire follow the combinational equations, so stall=0 with dec_valid=0.
- raw_hit = (rs1_used && rs1!=0 && count[rs1]!=0) || (rs2_used && rs2!=0 && count[rs2]!=0).
- waw_full = rd_write && rd!=0 && count[rd]==MAX, where MAX = 2^CNT_WIDTH-1.
- stall = dec_valid && (raw_hit || waw_full).
- issue_fire = dec_valid && !stall && issue_ready.
- Hazard checks use registered counters only. A writeback in cycle N clears the hazard in cycle N+1 at the earliest; there is no same-cycle bypass.
- Per-register update each cycle:
  - inc = issue_fire && rd_write && rd==r && r!=0.
  - dec_wb = wb_valid && wb_rd==r.
  - dec_sq = squash_valid && squash_rd==r.
  - next = count + inc - dec_wb - dec_sq.
- Simultaneous events:
  - inc with one decrement → unchanged.
  - wb and squash on the same register → decrement by 2.
- Underflow: if the decrements exceed count+inc, the counter clamps at 0 and underflow_err sets. Register 0 events are ignored: no underflow, no change.
- flush_all has priority over every inc/dec in the same cycle. All counters go to 0 next cycle; underflow_err is retained.
- underflow_err clears only on reset.
- Overflow cannot occur, because waw_full blocks the issue.
- busy_mask is updated from the next-state counters, i.e. it is aligned with the counters. Bit 0 is always 0.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and waw_stall_cycles[31:0].
  - Both are async-reset to 0.
  - stall_cycles increments each cycle stall=1; waw_stall_cycles increments each cycle stall && !raw_hit.
  - Both saturate at 0xFFFFFFFF; flush_all does not clear them.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset, then issue rd=5 (write) with issue_ready=1 → issue_fire=1; next cycle busy_mask=0x00000020. Next instruction with rs1=5 used → stall=1 until the cycle after wb_valid, wb_rd=5.
- Issue a write to rd=0, then read rs1=0 → no stall, busy_mask stays 0, underflow_err=0.
- CNT_WIDTH=2, three back-to-back writes to rd=7 → count=3. A fourth write to rd=7 → stall=1 with no source hazard. One wb to 7 → the fourth issues next cycle.
- count[9]=1: issue a write to 9 with wb_valid, wb_rd=9 in the same cycle → count[9] stays 1, busy bit 9 stays set.
- count[3]=2: wb_rd=3 and squash_rd=3 in the same cycle → count 0. Further wb_rd=3 → underflow_err=1 and stays 1 through flush_all.
- flush_all together with an issue to rd=4 → next cycle busy_mask=0. Assert rst=0 mid-cycle → outputs clear without a clock edge.
